tempo_sequencer: RTL and testbench

Beat scheduler that owns a countdown divider and sequences it for song playback. It provides start/pause/stop control and glitch-free tempo changes, applied only at a tick boundary. It also counts beats within a measure and measures within a song. It sits between the game FSM (control, tempo from the chart) and the note-scroll/judgement logic, which consume `tick` and `measure_tick`.

---
 rtl/tempo_sequencer.sv | 148 ++++++++++++++
 tb/tb_tempo_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tempo_sequencer.sv
// Beat scheduler: countdown divider with start/pause/stop, tick-boundary tempo changes, beat/measure counters (TEMPO_SEQ_MEASURE_EN adds measures/DONE).
// Latency: first tick period+1 cycles after start is sampled; outputs decode registers only.
// Backpressure: period_ready drops while a tempo change is pending and rises after the reload that consumes it.
module tempo_sequencer #(
    parameter int                WIDTH             = 28,
    parameter int                BEATS_PER_MEASURE = 4,
    parameter int                MEASURE_W         = 8,
    parameter logic [WIDTH-1:0]  RESET_PERIOD      = WIDTH'(12_499_999)
) (
    input  logic                 clock,
    input  logic                 reset_b,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     period,
    input  logic                 period_valid,
    output logic                 period_ready,
    input  logic [MEASURE_W-1:0] num_measures,
    output logic                 tick,
    output logic [2:0]           beat_idx,
    output logic                 measure_tick,
    output logic [MEASURE_W-1:0] measure_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_MEASURE - 1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] pending_period;
    logic             pending;
    logic             accept;
    logic             last_beat;
    logic             song_end;

    assign tick         = (state == S_RUN) && (count == '0);
    assign last_beat    = (beat_idx == LAST_BEAT);
    assign busy         = (state == S_RUN) || (state == S_PAUSE);
    assign period_ready = !pending;
    assign accept       = period_valid && !pending;

`ifdef TEMPO_SEQ_MEASURE_EN
    logic [MEASURE_W-1:0] meas_cnt;
    logic [MEASURE_W-1:0] meas_next;

    assign measure_tick  = tick && last_beat;
    assign measure_count = meas_cnt;
    assign done          = (state == S_DONE);
    assign meas_next     = (meas_cnt == '1) ? meas_cnt : meas_cnt + MEASURE_W'(1);
    // num_measures of zero means an endless song
    assign song_end      = measure_tick && (num_measures != '0) && (meas_next == num_measures);
`else
    logic unused_num_measures;

    assign measure_tick        = 1'b0;
    assign measure_count       = '0;
    assign done                = 1'b0;
    assign song_end            = 1'b0;
    assign unused_num_measures = ^num_measures;
`endif

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state          <= S_IDLE;
            count          <= '0;
            beat_idx       <= '0;
            pending        <= 1'b0;
            pending_period <= '0;
            active_period  <= RESET_PERIOD;
`ifdef TEMPO_SEQ_MEASURE_EN
            meas_cnt       <= '0;
`endif
        end else if (stop) begin
            state    <= S_IDLE;
            count    <= '0;
            beat_idx <= '0;
            pending  <= 1'b0;
`ifdef TEMPO_SEQ_MEASURE_EN
            meas_cnt <= '0;
`endif
            // Heading to IDLE, so an offer taken in this cycle becomes the tempo directly
            if (accept)
                active_period <= period;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        beat_idx <= '0;
`ifdef TEMPO_SEQ_MEASURE_EN
                        meas_cnt <= '0;
`endif
                        if (pending) begin
                            count         <= pending_period;
                            active_period <= pending_period;
                            pending       <= 1'b0;
                        end else begin
                            count <= active_period;
                        end
                    end
                    if (accept)
                        active_period <= period;
                end
                S_RUN: begin
                    if (count != '0) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        beat_idx <= last_beat ? 3'd0 : beat_idx + 3'd1;
`ifdef TEMPO_SEQ_MEASURE_EN
                        if (measure_tick)
                            meas_cnt <= meas_next;
`endif
                        if (pending) begin
                            count         <= pending_period;
                            active_period <= pending_period;
                            pending       <= 1'b0;
                        end else begin
                            count <= active_period;
                        end
                    end
                    if (song_end)
                        state <= S_DONE;
                    else if (pause)
                        state <= S_PAUSE;
                    // accept implies pending was clear, so this never races the reload above
                    if (accept) begin
                        pending_period <= period;
                        pending        <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause)
                        state <= S_RUN;
                    if (accept) begin
                        pending_period <= period;
                        pending        <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tempo_sequencer.sv
// Bench for tempo_sequencer: directed scenarios then random control/tempo traffic,
// checked every cycle against an absolute-time beat model.
`timescale 1ns/1ps
module tb_tempo_sequencer;

    localparam int             W  = 28;
    localparam int             B  = 4;
    localparam int             MW = 8;
    localparam logic [W-1:0]   RP = 28'd6;
`ifdef TEMPO_SEQ_MEASURE_EN
    localparam bit MEAS_EN = 1'b1;
`else
    localparam bit MEAS_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_b;
    logic          start, pause, stop, period_valid;
    logic [W-1:0]  period;
    logic [MW-1:0] num_measures;
    logic          period_ready, tick, measure_tick, busy, done;
    logic [2:0]    beat_idx;
    logic [MW-1:0] measure_count;

    tempo_sequencer #(
        .WIDTH(W), .BEATS_PER_MEASURE(B), .MEASURE_W(MW), .RESET_PERIOD(RP)
    ) dut (
        .clock(clock), .reset_b(reset_b), .start(start), .pause(pause), .stop(stop),
        .period(period), .period_valid(period_valid), .period_ready(period_ready),
        .num_measures(num_measures), .tick(tick), .beat_idx(beat_idx),
        .measure_tick(measure_tick), .measure_count(measure_count),
        .busy(busy), .done(done)
    );

    initial forever #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: 0 idle, 1 run, 2 pause, 3 done; ticks land at absolute cycle m_tick_at.
    int     m_st;
    longint m_cyc, m_tick_at;
    int     m_ticks, m_act, m_pv;
    bit     m_pend;
    logic [MW-1:0] nm_q;

    function automatic int sat_meas(input int t);
        return (t / B > 255) ? 255 : t / B;
    endfunction

    function automatic logic [15:0] exp_outs();
        logic t;
        logic [7:0] mc;
        t  = (m_st == 1) && (m_cyc == m_tick_at);
        mc = MEAS_EN ? 8'(sat_meas(m_ticks)) : 8'd0;
        return {t, 3'(m_ticks % B), MEAS_EN && t && (m_ticks % B == B - 1), mc,
                (m_st == 1 || m_st == 2), MEAS_EN && (m_st == 3), !m_pend};
    endfunction

    task automatic m_reset();
        m_st = 0; m_ticks = 0; m_pend = 0; m_act = int'(RP); m_pv = 0; m_tick_at = 0;
    endtask

    task automatic m_update();
        logic t;
        logic acc;
        int   ost;
        int   p;
        t   = (m_st == 1) && (m_cyc == m_tick_at);
        acc = period_valid && !m_pend;
        ost = m_st;
        if (stop) begin
            m_st = 0; m_ticks = 0; m_pend = 0;
        end else if (start && (m_st == 0 || m_st == 3)) begin
            p = m_pend ? m_pv : m_act;
            if (m_pend) m_act = m_pv;
            m_pend = 0; m_ticks = 0; m_st = 1;
            m_tick_at = m_cyc + 1 + p;
        end else if (m_st == 1) begin
            if (t) begin
                p = m_pend ? m_pv : m_act;
                if (m_pend) m_act = m_pv;
                m_pend = 0;
                m_tick_at = m_cyc + 1 + p;
                m_ticks++;
                if (MEAS_EN && num_measures != 0 && m_ticks % B == 0 &&
                    sat_meas(m_ticks) == int'(num_measures))
                    m_st = 3;
            end
            if (m_st == 1 && pause) m_st = 2;
        end else if (m_st == 2) begin
            m_tick_at++;
            if (!pause) m_st = 1;
        end
        if (acc) begin
            if (ost == 1 || ost == 2) begin
                m_pv = int'(period); m_pend = 1;
            end else begin
                m_act = int'(period);
            end
        end
        m_cyc++;
    endtask

    int s_tick, s_beat, s_mt, s_mc, s_busy, s_done, s_rdy;

    // One cycle: sample and check at negedge, then drive inputs for the next edge.
    task automatic step(input bit st_i, input bit pa_i, input bit sp_i, input bit v_i, input int p_i);
        @(negedge clock);
        check_val("cycle", {16'd0, tick, beat_idx, measure_tick, measure_count, busy, done, period_ready},
                  {16'd0, exp_outs()});
        s_tick = int'(tick); s_beat = int'(beat_idx); s_mt = int'(measure_tick);
        s_mc = int'(measure_count); s_busy = int'(busy); s_done = int'(done); s_rdy = int'(period_ready);
        start = st_i; pause = pa_i; stop = sp_i; period_valid = v_i; period = W'(p_i);
        num_measures = nm_q;
        m_update();
    endtask

    task automatic gap_to_tick(input bit pa, output int g);
        g = 0;
        for (int i = 1; i <= 100; i++) begin
            step(0, pa, 0, 0, 0);
            if (s_tick != 0) begin
                g = i;
                break;
            end
        end
    endtask

    int t_cnt, mt_cnt;
    task automatic run_steps(input int n, input bit pa);
        t_cnt = 0; mt_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(0, pa, 0, 0, 0);
            t_cnt += s_tick; mt_cnt += s_mt;
        end
    endtask

    task automatic wait_count(input longint want);
        int i;
        i = 0;
        while ((m_tick_at - m_cyc) != want && i < 40) begin
            step(0, 0, 0, 0, 0);
            i++;
        end
        check_val("wait_bound", 32'(i < 40), 32'd1);
    endtask

    int g;
    bit pa_lvl;

    initial begin
        reset_b = 0; start = 0; pause = 0; stop = 0; period_valid = 0; period = '0;
        nm_q = '0; num_measures = '0;
        m_reset(); m_cyc = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_ready", 32'(period_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        reset_b = 1;

        // Tempo 3 loaded in IDLE, then start: tick every 4 cycles, beats 0,1,2,3,0
        step(0, 0, 0, 1, 3);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            gap_to_tick(0, g);
            check_val("tick_gap", 32'(g), 32'd4);
            check_val("beat_seq", 32'(s_beat), 32'(i % B));
        end

        // Mid-interval change to 1; second offer while pending is refused
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 5);
        check_val("rdy_drop", 32'(s_rdy), 32'd0);
        step(0, 0, 0, 0, 0);
        check_val("old_tick", 32'(s_tick), 32'd1);
        gap_to_tick(0, g);
        check_val("new_gap", 32'(g), 32'd2);
        gap_to_tick(0, g);
        check_val("new_gap2", 32'(g), 32'd2);

        // Pause at count 2 for 10 cycles, then resume
        step(0, 0, 0, 1, 3);
        wait_count(2);
        run_steps(10, 1);
        check_val("pause_ticks", 32'(t_cnt), 32'd0);
        step(0, 0, 0, 0, 0);
        gap_to_tick(0, g);
        check_val("resume_gap", 32'(g), 32'd2);

        // Pause asserted in a tick cycle: that tick still fires once
        wait_count(0);
        step(0, 1, 0, 0, 0);
        check_val("tick_on_pause", 32'(s_tick), 32'd1);
        run_steps(6, 1);
        check_val("pause_hold", 32'(t_cnt), 32'd0);
        step(0, 0, 0, 0, 0);

        // stop and start together while running
        run_steps(3, 0);
        step(1, 0, 1, 0, 0);
        run_steps(6, 0);
        check_val("stop_ticks", 32'(t_cnt), 32'd0);
        check_val("stop_busy", 32'(s_busy), 32'd0);
        check_val("stop_beat", 32'(s_beat), 32'd0);

`ifdef TEMPO_SEQ_MEASURE_EN
        // Two measures at P=0: 8 ticks, measure strobes on 4 and 8, then DONE
        nm_q = 8'd2;
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        run_steps(12, 0);
        check_val("song_ticks", 32'(t_cnt), 32'd8);
        check_val("song_mticks", 32'(mt_cnt), 32'd2);
        check_val("song_done", 32'(s_done), 32'd1);
        check_val("song_busy", 32'(s_busy), 32'd0);
        check_val("song_mcount", 32'(s_mc), 32'd2);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_val("restart_mc", 32'(s_mc), 32'd0);
        check_val("restart_busy", 32'(s_busy), 32'd1);
        step(0, 0, 1, 0, 0);
        nm_q = '0;
`endif

        // Asynchronous reset between edges while running
        step(1, 0, 0, 0, 0);
        run_steps(5, 0);
        @(posedge clock);
        #2 reset_b = 0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_tick", 32'(tick), 32'd0);
        check_val("arst_beat", 32'(beat_idx), 32'd0);
        check_val("arst_ready", 32'(period_ready), 32'd1);
        m_reset();
        @(negedge clock);
        reset_b = 1;
        step(1, 0, 0, 0, 0);
        gap_to_tick(0, g);
        check_val("rst_period", 32'(g), 32'(int'(RP) + 1));

        // Random control and tempo traffic
        pa_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            bit st_r, sp_r, v_r;
            st_r = ($urandom % 40) == 0;
            sp_r = ($urandom % 90) == 0;
            v_r  = !sp_r && (($urandom % 6) == 0);
            if (($urandom % 12) == 0) pa_lvl = !pa_lvl;
            if (($urandom % 150) == 0) nm_q = MW'($urandom % 4);
            step(st_r, pa_lvl, sp_r, v_r, int'($urandom % 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
